// File: rtl/rv_pkg.sv
// Shared encodings for the single-cycle RV32I-subset core: opcodes, ALU control,
// immediate-format selects, ALU-op classes and the main-decoder control bundle.
package rv_pkg;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_I   = 7'b0010011;

  localparam logic [2:0] ALUCTL_ADD = 3'b000;
  localparam logic [2:0] ALUCTL_SUB = 3'b001;
  localparam logic [2:0] ALUCTL_AND = 3'b010;
  localparam logic [2:0] ALUCTL_OR  = 3'b011;
  localparam logic [2:0] ALUCTL_SLT = 3'b101;

  localparam logic [1:0] IMMSRC_I = 2'b00;
  localparam logic [1:0] IMMSRC_S = 2'b01;
  localparam logic [1:0] IMMSRC_B = 2'b10;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  typedef struct packed {
    logic       regwrite;
    logic [1:0] immsrc;
    logic       alusrc;
    logic       memwrite;
    logic       resultsrc;
    logic       branch;
    logic [1:0] aluop;
  } main_ctl_t;

endpackage

// File: rtl/rv_ctrl_dec.sv
// Control unit: main decoder (opcode -> datapath controls), ALU decoder
// (aluop/funct3/funct7b5 -> alucontrol) and branch resolution (pcsrc).
module rv_ctrl_dec
  import rv_pkg::*;
(
  input  logic [6:0] op,
  input  logic       zero,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  output logic       regwrite,
  output logic [1:0] immsrc,
  output logic       alusrc,
  output logic       memwrite,
  output logic       resultsrc,
  output logic       pcsrc,
  output logic [2:0] alucontrol
);

  main_ctl_t ctl;

  always_comb begin
    ctl = '0;
    case (op)
      OP_LW:  ctl = '{regwrite: 1'b1, immsrc: IMMSRC_I, alusrc: 1'b1, memwrite: 1'b0,
                      resultsrc: 1'b1, branch: 1'b0, aluop: ALUOP_ADD};
      OP_SW:  ctl = '{regwrite: 1'b0, immsrc: IMMSRC_S, alusrc: 1'b1, memwrite: 1'b1,
                      resultsrc: 1'b0, branch: 1'b0, aluop: ALUOP_ADD};
      OP_R:   ctl = '{regwrite: 1'b1, immsrc: IMMSRC_I, alusrc: 1'b0, memwrite: 1'b0,
                      resultsrc: 1'b0, branch: 1'b0, aluop: ALUOP_FUNCT};
      OP_BEQ: ctl = '{regwrite: 1'b0, immsrc: IMMSRC_B, alusrc: 1'b0, memwrite: 1'b0,
                      resultsrc: 1'b0, branch: 1'b1, aluop: ALUOP_SUB};
      OP_I:   ctl = '{regwrite: 1'b1, immsrc: IMMSRC_I, alusrc: 1'b1, memwrite: 1'b0,
                      resultsrc: 1'b0, branch: 1'b0, aluop: ALUOP_FUNCT};
      default: ctl = '0;
    endcase
  end

  always_comb begin
    alucontrol = ALUCTL_ADD;
    case (ctl.aluop)
      ALUOP_SUB: alucontrol = ALUCTL_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          // Only R-type (op[5]=1) may select sub; addi with imm[10]=1 must stay add.
          3'b000:  alucontrol = (op[5] && funct7b5) ? ALUCTL_SUB : ALUCTL_ADD;
          3'b010:  alucontrol = ALUCTL_SLT;
          3'b110:  alucontrol = ALUCTL_OR;
          3'b111:  alucontrol = ALUCTL_AND;
          default: alucontrol = ALUCTL_ADD;
        endcase
      end
      default: alucontrol = ALUCTL_ADD;
    endcase
  end

  assign regwrite  = ctl.regwrite;
  assign immsrc    = ctl.immsrc;
  assign alusrc    = ctl.alusrc;
  assign memwrite  = ctl.memwrite;
  assign resultsrc = ctl.resultsrc;
  assign pcsrc     = ctl.branch & zero;

endmodule

// File: rtl/rv32_core_sc.sv
// Single-cycle RV32I-subset core: PC, ROM, register file, immediate extender,
// ALU, data RAM and control; decoded controls are exported for observation.
module rv32_core_sc
  import rv_pkg::*;
#(
  parameter int unsigned IMEM_DEPTH = 64,
  parameter int unsigned DMEM_DEPTH = 64,
  parameter string       IMEM_FILE  = "program.hex"
) (
  input  logic       clk,
  input  logic       reset,
  output logic [1:0] immsrc,
  output logic       resultsrc,
  output logic       memwrite,
  output logic       alusrc,
  output logic       regwrite,
  output logic       pcsrc
);

  localparam int unsigned IAW = $clog2(IMEM_DEPTH);
  localparam int unsigned DAW = $clog2(DMEM_DEPTH);

  logic [31:0] pc, pcnext, pcplus4, pctarget;
  logic [31:0] instr, immext, rd1, rd2, srcb;
  logic [31:0] aluresult, readdata, result;
  logic [2:0]  alucontrol;
  logic        zero;

  logic [31:0] imem [IMEM_DEPTH];
  logic [31:0] dmem [DMEM_DEPTH];
  logic [31:0] rf   [32];

  initial begin
    for (int unsigned i = 0; i < IMEM_DEPTH; i++) imem[i] = '0;
    for (int unsigned i = 0; i < DMEM_DEPTH; i++) dmem[i] = '0;
  end

  assign instr = imem[pc[IAW+1:2]];

  rv_ctrl_dec u_ctrl (
    .op         (instr[6:0]),
    .zero       (zero),
    .funct3     (instr[14:12]),
    .funct7b5   (instr[30]),
    .regwrite   (regwrite),
    .immsrc     (immsrc),
    .alusrc     (alusrc),
    .memwrite   (memwrite),
    .resultsrc  (resultsrc),
    .pcsrc      (pcsrc),
    .alucontrol (alucontrol)
  );

  always_comb begin
    case (immsrc)
      IMMSRC_I: immext = {{20{instr[31]}}, instr[31:20]};
      IMMSRC_S: immext = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMMSRC_B: immext = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      default:  immext = '0;
    endcase
  end

  // rf[0] is cleared by reset and never written, so x0 reads as zero.
  assign rd1  = rf[instr[19:15]];
  assign rd2  = rf[instr[24:20]];
  assign srcb = alusrc ? immext : rd2;

  always_comb begin
    case (alucontrol)
      ALUCTL_ADD: aluresult = rd1 + srcb;
      ALUCTL_SUB: aluresult = rd1 - srcb;
      ALUCTL_AND: aluresult = rd1 & srcb;
      ALUCTL_OR:  aluresult = rd1 | srcb;
      ALUCTL_SLT: aluresult = {31'd0, $signed(rd1) < $signed(srcb)};
      default:    aluresult = '0;
    endcase
  end

  assign zero     = (aluresult == '0);
  assign readdata = dmem[aluresult[DAW+1:2]];
  assign result   = resultsrc ? readdata : aluresult;

  assign pcplus4  = pc + 32'd4;
  assign pctarget = pc + immext;
  assign pcnext   = pcsrc ? pctarget : pcplus4;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pc <= '0;
    else        pc <= pcnext;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < 32; i++) rf[i] <= '0;
    end else if (regwrite && (instr[11:7] != 5'd0)) begin
      rf[instr[11:7]] <= result;
    end
  end

  // RAM is never cleared; reset only blocks writes while it is held low.
  always_ff @(posedge clk or negedge reset) begin
    if (reset && memwrite) dmem[aluresult[DAW+1:2]] <= rd2;
  end

endmodule

// File: tb/tb_rv32_core_sc.sv
// Bench for rv32_core_sc: decode table under reset, a directed program with
// hand-derived results, and random programs checked against an ISA-level model.
module tb_rv32_core_sc;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] immsrc;
  logic       resultsrc, memwrite, alusrc, regwrite, pcsrc;
  logic [6:0] act_ctrl;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  rv32_core_sc #(.IMEM_FILE("")) dut (
    .clk       (clk),
    .reset     (reset),
    .immsrc    (immsrc),
    .resultsrc (resultsrc),
    .memwrite  (memwrite),
    .alusrc    (alusrc),
    .regwrite  (regwrite),
    .pcsrc     (pcsrc)
  );

  assign act_ctrl = {regwrite, immsrc, alusrc, memwrite, resultsrc, pcsrc};

  // ISA-level reference state
  logic [31:0] m_reg [32];
  logic [31:0] m_mem [64];
  logic [31:0] m_rom [64];
  logic [31:0] m_pc;

  logic [6:0]  e_ctrl;
  logic [31:0] e_npc, e_wval, e_mval;
  logic [4:0]  e_rd;
  logic [5:0]  e_midx;
  bit          e_wr, e_mw;

  typedef struct {
    logic [31:0] instr;
    logic [6:0]  ctrl;
  } dec_vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [6:0]  ctrl;
    int unsigned kind;   // 0 none, 1 register, 2 RAM word
    int unsigned idx;
    logic [31:0] val;
  } seq_vec_t;

  dec_vec_t dvec [9];
  seq_vec_t svec [11];
  logic [31:0] prog [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic load_rom(input logic [31:0] w, input int unsigned idx);
    dut.imem[idx] = w;
    m_rom[idx]    = w;
  endtask

  task automatic model_reset();
    m_pc = '0;
    for (int unsigned i = 0; i < 32; i++) m_reg[i] = '0;
  endtask

  function automatic logic [31:0] alu_ref(input logic [2:0] f3, input logic neg,
                                          input logic [31:0] x, input logic [31:0] y);
    case (f3)
      3'd0:    return neg ? x - y : x + y;
      3'd2:    return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      3'd6:    return x | y;
      3'd7:    return x & y;
      default: return x + y;
    endcase
  endfunction

  task automatic model_eval();
    logic [31:0] ins, a, b, ii, si, bi, addr;
    logic [5:0]  pidx;
    pidx = m_pc[7:2];
    ins  = m_rom[pidx];
    a    = m_reg[ins[19:15]];
    b    = m_reg[ins[24:20]];
    ii   = 32'($signed(ins) >>> 20);
    si   = (ii & ~32'h1F) | 32'(ins[11:7]);
    bi   = (32'($signed(ins) >>> 31) << 12) | (32'(ins[7]) << 11)
         | (32'(ins[30:25]) << 5) | (32'(ins[11:8]) << 1);
    e_ctrl = '0; e_npc = m_pc + 32'd4; e_wr = 0; e_rd = ins[11:7];
    e_wval = '0; e_mw = 0; e_midx = '0; e_mval = '0;
    case (ins[6:0])
      7'h03: begin
        addr = a + ii; e_ctrl = 7'b1001010; e_wr = 1; e_wval = m_mem[addr[7:2]];
      end
      7'h23: begin
        addr = a + si; e_ctrl = 7'b0011100; e_mw = 1; e_midx = addr[7:2]; e_mval = b;
      end
      7'h33: begin
        e_ctrl = 7'b1000000; e_wr = 1; e_wval = alu_ref(ins[14:12], ins[30], a, b);
      end
      7'h13: begin
        e_ctrl = 7'b1001000; e_wr = 1; e_wval = alu_ref(ins[14:12], 1'b0, a, ii);
      end
      7'h63: begin
        e_ctrl = (a == b) ? 7'b0100001 : 7'b0100000;
        if (a == b) e_npc = m_pc + bi;
      end
      default: ;
    endcase
  endtask

  task automatic model_commit();
    if (e_wr && e_rd != 5'd0) m_reg[e_rd] = e_wval;
    if (e_mw) m_mem[e_midx] = e_mval;
    m_pc = e_npc;
  endtask

  task automatic run_cycle(input string tag);
    model_eval();
    check({tag, " ctrl"}, 32'(act_ctrl), 32'(e_ctrl));
    @(posedge clk); #1;
    model_commit();
    check({tag, " pc"}, dut.pc, m_pc);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [4:0]  rd, rs1, rs2;
    logic [11:0] imm;
    logic [2:0]  f3;
    logic [12:0] bo;
    logic [31:0] w;
    logic [2:0]  f3set [4];
    int          offs  [5];
    f3set = '{3'd0, 3'd2, 3'd6, 3'd7};
    offs  = '{-8, -4, 8, 12, 16};
    rd  = 5'($urandom_range(0, 7));
    rs1 = 5'($urandom_range(0, 7));
    rs2 = 5'($urandom_range(0, 7));
    imm = 12'($urandom);
    f3  = ($urandom_range(0, 5) == 0) ? 3'($urandom) : f3set[$urandom_range(0, 3)];
    case ($urandom_range(0, 9))
      0, 1, 2: w = {imm, rs1, f3, rd, 7'b0010011};
      3, 4:    w = {1'b0, 1'($urandom), 5'd0, rs2, rs1, f3, rd, 7'b0110011};
      5:       w = {imm, rs1, 3'b010, rd, 7'b0000011};
      6:       w = {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
      7: begin
        bo = 13'(offs[$urandom_range(0, 4)]);
        w  = {bo[12], bo[10:5], rs2, rs1, 3'b000, bo[4:1], bo[11], 7'b1100011};
      end
      8:       w = {25'($urandom), 7'b0110111};
      default: w = '0;
    endcase
    return w;
  endfunction

  initial begin
    dvec[0] = '{32'h00500093, 7'b1001000};  // addi x1,x0,5
    dvec[1] = '{32'h00102423, 7'b0011100};  // sw x1,8(x0)
    dvec[2] = '{32'h00802103, 7'b1001010};  // lw x2,8(x0)
    dvec[3] = '{32'h00208463, 7'b0100001};  // beq x1,x2 with both zero
    dvec[4] = '{32'h402081B3, 7'b1000000};  // sub
    dvec[5] = '{32'h0020E333, 7'b1000000};  // or
    dvec[6] = '{32'h00000000, 7'b0000000};  // unknown opcode
    dvec[7] = '{32'h0000006F, 7'b0000000};  // jal: unsupported
    dvec[8] = '{32'h0050A093, 7'b1001000};  // slti

    prog[0]  = 32'h00500093;  // addi x1,x0,5
    prog[1]  = 32'h00102423;  // sw   x1,8(x0)
    prog[2]  = 32'h00802103;  // lw   x2,8(x0)
    prog[3]  = 32'h00208463;  // beq  x1,x2,+8 (taken)
    prog[4]  = 32'h00900093;  // addi x1,x0,9 (skipped)
    prog[5]  = 32'h00700113;  // addi x2,x0,7
    prog[6]  = 32'h00208463;  // beq  x1,x2,+8 (not taken)
    prog[7]  = 32'h402081B3;  // sub  x3,x1,x2
    prog[8]  = 32'h0020A233;  // slt  x4,x1,x2
    prog[9]  = 32'h0020F2B3;  // and  x5,x1,x2
    prog[10] = 32'h0020E333;  // or   x6,x1,x2
    prog[11] = 32'h00000000;  // nop

    svec[0]  = '{32'd0,  7'b1001000, 1, 1, 32'd5};
    svec[1]  = '{32'd4,  7'b0011100, 2, 2, 32'd5};
    svec[2]  = '{32'd8,  7'b1001010, 1, 2, 32'd5};
    svec[3]  = '{32'd12, 7'b0100001, 0, 0, 32'd0};
    svec[4]  = '{32'd20, 7'b1001000, 1, 2, 32'd7};
    svec[5]  = '{32'd24, 7'b0100000, 0, 0, 32'd0};
    svec[6]  = '{32'd28, 7'b1000000, 1, 3, 32'hFFFFFFFE};
    svec[7]  = '{32'd32, 7'b1000000, 1, 4, 32'd1};
    svec[8]  = '{32'd36, 7'b1000000, 1, 5, 32'd5};
    svec[9]  = '{32'd40, 7'b1000000, 1, 6, 32'd7};
    svec[10] = '{32'd44, 7'b0000000, 0, 0, 32'd0};

    for (int unsigned i = 0; i < 64; i++) m_mem[i] = '0;
    model_reset();
    reset = 1'b0;
    #1;
    for (int unsigned i = 0; i < 64; i++) load_rom('0, i);

    // Decode of ROM[0] while reset is held low; nothing may be written.
    for (int unsigned v = 0; v < 9; v++) begin
      load_rom(dvec[v].instr, 0);
      @(posedge clk); #1;
      check($sformatf("rst_dec%0d ctrl", v), 32'(act_ctrl), 32'(dvec[v].ctrl));
      check($sformatf("rst_dec%0d pc", v), dut.pc, 32'd0);
    end
    check("rst no regwrite x1", dut.rf[1], 32'd0);

    for (int unsigned i = 0; i < 12; i++) load_rom(prog[i], i);
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    check("hold pc", dut.pc, 32'd0);
    check("hold ctrl", 32'(act_ctrl), 32'(7'b1001000));
    @(negedge clk); reset = 1'b1;

    for (int unsigned s = 0; s < 11; s++) begin
      check($sformatf("seq%0d pc_hand", s), dut.pc, svec[s].pc);
      check($sformatf("seq%0d ctrl_hand", s), 32'(act_ctrl), 32'(svec[s].ctrl));
      run_cycle($sformatf("seq%0d", s));
      if (svec[s].kind == 1)
        check($sformatf("seq%0d x%0d", s, svec[s].idx), dut.rf[svec[s].idx], svec[s].val);
      else if (svec[s].kind == 2)
        check($sformatf("seq%0d ram%0d", s, svec[s].idx), dut.dmem[svec[s].idx], svec[s].val);
    end
    check("nop pc", dut.pc, 32'd48);
    check("nop keeps x3", dut.rf[3], 32'hFFFFFFFE);
    check("nop keeps ram2", dut.dmem[2], 32'd5);

    // Reset asserted between edges takes effect without a clock.
    #2; reset = 1'b0; #1;
    check("async rst pc", dut.pc, 32'd0);
    check("async rst x1", dut.rf[1], 32'd0);
    check("async rst ctrl", 32'(act_ctrl), 32'(7'b1001000));
    model_reset();
    @(negedge clk); reset = 1'b1;
    for (int unsigned k = 0; k < 3; k++) begin
      run_cycle($sformatf("restart%0d", k));
      check($sformatf("restart%0d pc_hand", k), dut.pc, 32'(4 * (k + 1)));
    end

    for (int unsigned r = 0; r < 3; r++) begin
      reset = 1'b0;
      for (int unsigned i = 0; i < 64; i++) load_rom(rand_instr(), i);
      model_reset();
      @(negedge clk); reset = 1'b1;
      for (int unsigned c = 0; c < 60; c++) begin
        if (r == 1 && c == 30) begin
          #2; reset = 1'b0; #1;
          check("rnd async rst pc", dut.pc, 32'd0);
          model_reset();
          @(negedge clk); reset = 1'b1;
        end
        run_cycle($sformatf("rnd%0d_%0d", r, c));
      end
      for (int unsigned i = 1; i < 32; i++)
        check($sformatf("rnd%0d x%0d", r, i), dut.rf[i], m_reg[i]);
      for (int unsigned i = 0; i < 64; i++)
        check($sformatf("rnd%0d ram%0d", r, i), dut.dmem[i], m_mem[i]);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
